// File: rtl/intan_cmd_sequencer_if.sv
// Signal bundle of intan_cmd_sequencer: host run/config, SPI-generator slot side, sample stream.
// id_err exists only when INTAN_ID_CHECK_EN is defined.
interface intan_cmd_sequencer_if;
   logic        enable;
   logic        frame_done;
   logic [15:0] result_in;
   logic [15:0] command;
   logic        interface_on;
   logic        cfg_wr;
   logic [15:0] cfg_data;
   logic        cfg_full;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic [5:0]  sample_chan;
   logic        sweep_done;
   logic        busy;
`ifdef INTAN_ID_CHECK_EN
   logic        id_err;
`endif

   modport master (
      output enable, frame_done, result_in, cfg_wr, cfg_data,
      input  command, interface_on, cfg_full, sample_valid, sample_data,
             sample_chan, sweep_done, busy
`ifdef INTAN_ID_CHECK_EN
      , input id_err
`endif
   );

   modport slave (
      input  enable, frame_done, result_in, cfg_wr, cfg_data,
      output command, interface_on, cfg_full, sample_valid, sample_data,
             sample_chan, sweep_done, busy
`ifdef INTAN_ID_CHECK_EN
      , output id_err
`endif
   );
endinterface

// File: rtl/intan_cmd_sequencer.sv
// Per-frame command slot scheduler for the Intan SPI generator with result tagging.
// Optional chip-ID readback after every sweep: define INTAN_ID_CHECK_EN.
module intan_cmd_sequencer #(
   parameter int NUM_CH      = 32,
   parameter int CFG_DEPTH   = 4,
   parameter int CAL_DUMMIES = 9
) (
   input logic                  clk,
   input logic                  reset,
   intan_cmd_sequencer_if.slave bus
);
   localparam int AW         = $clog2(CFG_DEPTH);
   localparam int CALW       = $clog2(CAL_DUMMIES + 1);
   localparam int LAST_I     = NUM_CH - 1;
   localparam int CAL_LAST_I = CAL_DUMMIES - 1;
   localparam logic [5:0]      LAST_CH  = LAST_I[5:0];
   localparam logic [CALW-1:0] CAL_LAST = CAL_LAST_I[CALW-1:0];
   localparam logic [AW:0]     FULL_CNT = CFG_DEPTH[AW:0];
   localparam logic [15:0] CMD_DUMMY = 16'hFF00;
   localparam logic [15:0] CMD_CAL   = 16'h5500;

   typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

   state_t            state;
   logic [15:0]       command_q;
   logic              iface_q;
   logic [5:0]        ch;
   logic [CALW-1:0]   cal_cnt;
   logic [15:0]       fifo_mem [CFG_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              push, pop, id_slot;
   logic [1:0]        tag_vld, tag_conv;
   logic [1:0][5:0]   tag_chan;
   logic              smp_vld_q, sweep_q;
   logic [15:0]       smp_data_q;
   logic [5:0]        smp_chan_q;

`ifdef INTAN_ID_CHECK_EN
   localparam logic [15:0] CMD_ID = 16'hE800;
   logic       id_pend;
   logic [1:0] tag_id;
   logic       id_err_q;
   assign id_slot    = id_pend;
   assign bus.id_err = id_err_q;
`else
   assign id_slot = 1'b0;
`endif

   assign bus.cfg_full = (count == FULL_CNT);
   assign push = bus.cfg_wr && !bus.cfg_full;
   // Mirrors the RUN-slot priority below: ID slot first, then config, then CONVERT.
   assign pop  = bus.frame_done && bus.enable && (state == RUN) && !id_slot && (count != '0);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.cfg_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // Slot scheduler: everything advances only at a frame boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         command_q <= CMD_DUMMY;
         iface_q   <= 1'b0;
         ch        <= '0;
         cal_cnt   <= '0;
         tag_vld   <= '0;
         tag_conv  <= '0;
         tag_chan  <= '0;
`ifdef INTAN_ID_CHECK_EN
         id_pend   <= 1'b0;
         tag_id    <= '0;
`endif
      end else if (bus.frame_done) begin
         tag_vld     <= {tag_vld[0], 1'b0};
         tag_conv    <= {tag_conv[0], 1'b0};
         tag_chan[1] <= tag_chan[0];
         tag_chan[0] <= '0;
`ifdef INTAN_ID_CHECK_EN
         tag_id      <= {tag_id[0], 1'b0};
`endif
         command_q   <= CMD_DUMMY;
         iface_q     <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.enable) begin
                  state      <= CAL;
                  command_q  <= CMD_CAL;
                  iface_q    <= 1'b1;
                  cal_cnt    <= '0;
                  tag_vld[0] <= 1'b1;
               end
            end
            CAL, RUN: begin
               if (!bus.enable) begin
                  state <= IDLE;
                  ch    <= '0;
`ifdef INTAN_ID_CHECK_EN
                  id_pend <= 1'b0;
`endif
               end else begin
                  iface_q    <= 1'b1;
                  tag_vld[0] <= 1'b1;
                  if (state == CAL) begin
                     cal_cnt <= cal_cnt + CALW'(1);
                     if (cal_cnt == CAL_LAST) state <= RUN;
                  end else if (id_slot) begin
`ifdef INTAN_ID_CHECK_EN
                     command_q <= CMD_ID;
                     tag_id[0] <= 1'b1;
                     id_pend   <= 1'b0;
`endif
                  end else if (count != '0) begin
                     command_q <= fifo_mem[rd_ptr];
                  end else begin
                     command_q   <= {2'b00, ch, 8'h00};
                     tag_conv[0] <= 1'b1;
                     tag_chan[0] <= ch;
                     if (ch == LAST_CH) begin
                        ch <= '0;
`ifdef INTAN_ID_CHECK_EN
                        id_pend <= 1'b1;
`endif
                     end else begin
                        ch <= ch + 6'd1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result returned now belongs to the tag leaving stage 2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         smp_vld_q  <= 1'b0;
         sweep_q    <= 1'b0;
         smp_data_q <= '0;
         smp_chan_q <= '0;
      end else begin
         smp_vld_q <= 1'b0;
         sweep_q   <= 1'b0;
         if (bus.frame_done && tag_vld[1] && tag_conv[1]) begin
            smp_vld_q  <= 1'b1;
            smp_data_q <= bus.result_in;
            smp_chan_q <= tag_chan[1];
            sweep_q    <= (tag_chan[1] == LAST_CH);
         end
      end
   end

`ifdef INTAN_ID_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         id_err_q <= 1'b0;
      else if (bus.frame_done && tag_vld[1] && tag_id[1] && (bus.result_in[7:0] != 8'h49))
         id_err_q <= 1'b1;
   end
`endif

   assign bus.command      = command_q;
   assign bus.interface_on = iface_q;
   assign bus.sample_valid = smp_vld_q;
   assign bus.sample_data  = smp_data_q;
   assign bus.sample_chan  = smp_chan_q;
   assign bus.sweep_done   = sweep_q;
   assign bus.busy         = (state != IDLE);
endmodule
